// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Two-port (fetch / data) arbiter onto a single-ported unified
//             memory. One transaction outstanding at a time, data port wins
//             by default. Responses are routed back to the issuing port.
//             Optional fetch-fairness counter enabled by ARB_FAIRNESS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    // fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // memory port
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    // status
    output logic              busy,
    output logic              err_spurious
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT_I = 2'd1;
    localparam logic [1:0] ST_WAIT_D = 2'd2;

    // Out-of-range run limits would make the saturating 8-bit counter wrong.
    generate
        if (MAX_DATA_RUN < 1 || MAX_DATA_RUN > 255) begin : g_bad_run_limit
            $error("mem_arbiter: MAX_DATA_RUN must be within 1..255");
        end
    endgenerate

    logic [1:0] state_q, state_d;
    logic       err_spurious_q, err_spurious_d;
    logic       req_any;
    logic       fetch_forced;
    logic       sel_data;

`ifdef ARB_FAIRNESS_EN
    localparam logic [7:0] RUN_MAX = 8'(MAX_DATA_RUN);

    logic [7:0] run_cnt_q, run_cnt_d;

    // Fetch has waited through RUN_MAX data grants: it takes the next slot.
    always_comb begin
        fetch_forced = i_req && (run_cnt_q == RUN_MAX);
    end

    // Count consecutive data grants taken while fetch was waiting.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (i_gnt) begin
            run_cnt_d = 8'd0;
        end else if (d_gnt) begin
            if (!i_req) begin
                run_cnt_d = 8'd0;
            end else if (run_cnt_q != RUN_MAX) begin
                run_cnt_d = run_cnt_q + 8'd1;
            end
        end
    end

    // Fairness counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt_q <= 8'd0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end
`else
    // Strict data priority: fetch never overrides a pending data request.
    always_comb begin
        fetch_forced = 1'b0;
    end
`endif

    // Port selection: data unless fetch has been held off too long.
    always_comb begin
        req_any  = i_req | d_req;
        sel_data = d_req & ~fetch_forced;
    end

    // State and sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    // Next-state: leave IDLE on an accepted request, return on the response.
    always_comb begin
        state_d        = state_q;
        err_spurious_d = err_spurious_q;
        case (state_q)
            ST_IDLE: begin
                if (m_rvalid) begin
                    err_spurious_d = 1'b1;
                end
                if (m_gnt && req_any) begin
                    state_d = sel_data ? ST_WAIT_D : ST_WAIT_I;
                end
            end
            ST_WAIT_I, ST_WAIT_D: begin
                if (m_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: request mux and grants in IDLE, response routing in WAIT_x.
    always_comb begin
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;
        i_rvalid     = 1'b0;
        d_rvalid     = 1'b0;
        i_rdata      = m_rdata;
        d_rdata      = m_rdata;
        m_req        = 1'b0;
        m_we         = 1'b0;
        m_addr       = sel_data ? d_addr : i_addr;
        m_wdata      = sel_data ? d_wdata : '0;
        busy         = (state_q != ST_IDLE);
        err_spurious = err_spurious_q;
        case (state_q)
            ST_IDLE: begin
                // Grants are gated so nothing is accepted while in reset.
                if (!reset) begin
                    m_req = req_any;
                    m_we  = sel_data & d_we;
                    i_gnt = m_gnt & req_any & ~sel_data;
                    d_gnt = m_gnt & req_any & sel_data;
                end
            end
            ST_WAIT_I: i_rvalid = m_rvalid;
            ST_WAIT_D: d_rvalid = m_rvalid;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Directed self-checking bench for mem_arbiter. Inputs change on
//             the falling edge; outputs are sampled 1 ns later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_gnt;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;
    logic              busy;
    logic              err_spurious;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MAX_DATA_RUN (4)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_gnt        (i_gnt),
        .i_rvalid     (i_rvalid),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .m_req        (m_req),
        .m_we         (m_we),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_gnt        (m_gnt),
        .m_rvalid     (m_rvalid),
        .m_rdata      (m_rdata),
        .busy         (busy),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance to the next falling edge (input-change point).
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Settle combinational outputs before sampling.
    task automatic settle();
        #1;
    endtask

    initial begin
        logic [1:0] grant_seq [10];
        logic [1:0] g;

        reset    = 1'b1;
        i_req    = 1'b1;
        i_addr   = 32'h0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = 32'h0;
        d_wdata  = 32'h0;
        m_gnt    = 1'b1;
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;

        // ---------------- reset state ----------------
        next_cycle(); settle();
        check_val("rst_m_req",   {31'd0, m_req},        32'd0);
        check_val("rst_i_gnt",   {31'd0, i_gnt},        32'd0);
        check_val("rst_busy",    {31'd0, busy},         32'd0);
        check_val("rst_err",     {31'd0, err_spurious}, 32'd0);
        i_req = 1'b0;
        m_gnt = 1'b0;
        next_cycle();
        reset = 1'b0;

        // ---------------- single fetch, latency 1 ----------------
        next_cycle();
        i_req = 1'b1; i_addr = 32'h10; m_gnt = 1'b1; settle();
        check_val("f_i_gnt",  {31'd0, i_gnt}, 32'd1);
        check_val("f_d_gnt",  {31'd0, d_gnt}, 32'd0);
        check_val("f_m_addr", m_addr,         32'h10);
        check_val("f_m_we",   {31'd0, m_we},  32'd0);
        next_cycle();
        i_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; settle();
        check_val("f_i_rvalid", {31'd0, i_rvalid}, 32'd1);
        check_val("f_i_rdata",  i_rdata,           32'hDEADBEEF);
        check_val("f_busy1",    {31'd0, busy},     32'd1);
        check_val("f_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        check_val("f_m_req_w",  {31'd0, m_req},    32'd0);
        next_cycle();
        m_rvalid = 1'b0; settle();
        check_val("f_busy2", {31'd0, busy}, 32'd0);

        // ---------------- simultaneous requests ----------------
        next_cycle();
        i_req = 1'b1; i_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; settle();
        check_val("s_d_gnt",  {31'd0, d_gnt}, 32'd1);
        check_val("s_i_gnt0", {31'd0, i_gnt}, 32'd0);
        check_val("s_m_addr", m_addr,         32'h100);
        next_cycle();
        d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_1234; settle();
        check_val("s_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        check_val("s_d_rdata",  d_rdata,           32'h0000_1234);
        check_val("s_i_rv0",    {31'd0, i_rvalid}, 32'd0);
        check_val("s_i_gnt1",   {31'd0, i_gnt},    32'd0);
        next_cycle();
        m_rvalid = 1'b0; settle();
        check_val("s_i_gnt2",  {31'd0, i_gnt}, 32'd1);
        check_val("s_m_addr2", m_addr,         32'h20);
        next_cycle();
        i_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFE_0020; settle();
        check_val("s_i_rvalid", {31'd0, i_rvalid}, 32'd1);
        next_cycle();
        m_rvalid = 1'b0;

        // ---------------- write acknowledge, latency 3 ----------------
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h5A5A5A5A; settle();
        check_val("w_d_gnt",   {31'd0, d_gnt}, 32'd1);
        check_val("w_m_we",    {31'd0, m_we},  32'd1);
        check_val("w_m_wdata", m_wdata,        32'h5A5A5A5A);
        check_val("w_m_addr",  m_addr,         32'h44);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            d_req = 1'b0; d_we = 1'b0;
            m_rvalid = (c == 3); settle();
            check_val($sformatf("w_d_rvalid_c%0d", c), {31'd0, d_rvalid}, (c == 3) ? 32'd1 : 32'd0);
            check_val($sformatf("w_i_rvalid_c%0d", c), {31'd0, i_rvalid}, 32'd0);
            check_val($sformatf("w_busy_c%0d", c),     {31'd0, busy},     32'd1);
        end
        next_cycle();
        m_rvalid = 1'b0; settle();
        check_val("w_busy_end", {31'd0, busy}, 32'd0);

        // ---------------- fairness / strict priority ----------------
`ifdef ARB_FAIRNESS_EN
        grant_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
`else
        grant_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
`endif
        next_cycle();
        i_req = 1'b1; i_addr = 32'h300; d_req = 1'b1; d_addr = 32'h400;
        for (int k = 0; k < 10; k++) begin
            m_rvalid = 1'b0; settle();
            g = {d_gnt, i_gnt};
            check_val($sformatf("fair_grant%0d", k), {30'd0, g}, {30'd0, grant_seq[k]});
            next_cycle();
            m_rvalid = 1'b1;
            next_cycle();
        end
        i_req = 1'b0; d_req = 1'b0; m_rvalid = 1'b0;

        // ---------------- reset mid-transaction ----------------
        next_cycle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; settle();
        check_val("r_d_gnt", {31'd0, d_gnt}, 32'd1);
        next_cycle();
        d_req = 1'b0; reset = 1'b1; settle();
        check_val("r_busy_in_rst", {31'd0, busy}, 32'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        m_rvalid = 1'b1; settle();
        check_val("r_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        next_cycle();
        m_rvalid = 1'b0; settle();
        check_val("r_err_set",  {31'd0, err_spurious}, 32'd1);
        check_val("r_busy_end", {31'd0, busy},         32'd0);
        next_cycle(); settle();
        check_val("r_err_sticky", {31'd0, err_spurious}, 32'd1);
        reset = 1'b1; settle();
        check_val("r_err_clear", {31'd0, err_spurious}, 32'd0);
        next_cycle();
        reset = 1'b0;

        // ---------------- memory stall ----------------
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            i_req = 1'b1; i_addr = 32'h30; m_gnt = 1'b0;
            if (c == 3) begin
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
            end
            settle();
            check_val($sformatf("st_i_gnt_c%0d", c), {31'd0, i_gnt}, 32'd0);
            check_val($sformatf("st_busy_c%0d", c),  {31'd0, busy},  32'd0);
            check_val($sformatf("st_m_addr_c%0d", c), m_addr, (c >= 3) ? 32'h200 : 32'h30);
        end
        next_cycle();
        m_gnt = 1'b1; settle();
        check_val("st_d_gnt", {31'd0, d_gnt}, 32'd1);
        check_val("st_i_gnt", {31'd0, i_gnt}, 32'd0);
        next_cycle();
        d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0BAD_F00D; settle();
        check_val("st_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        next_cycle();
        m_rvalid = 1'b0; settle();
        check_val("st_i_gnt_after", {31'd0, i_gnt}, 32'd1);
        check_val("st_m_addr_i",    m_addr,         32'h30);
        next_cycle();
        i_req = 1'b0; m_rvalid = 1'b1; settle();
        check_val("st_i_rvalid", {31'd0, i_rvalid}, 32'd1);
        next_cycle();
        m_rvalid = 1'b0;
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
